bus_arbiter: RTL and testbench

- Two-master arbiter sharing the single memory_top bus between CPU_top (master 0) and a second bus master such as a DMA or debug loader (master 1).
- Captures one-cycle request pulses from each master, grants round-robin, and issues one transaction at a time to memory.
- Routes the response pulse and read data back to the owning master.
- Includes a response timeout so a missing memory acknowledge cannot hang the system.

---
 rtl/bus_arbiter.sv | 153 +++++++++++++++
 tb/tb_bus_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter in front of memory_top: captures request pulses,
// issues one bus transaction at a time, and routes the response (or a timeout) back.
module bus_arbiter #(
    parameter int unsigned TIMEOUT      = 1024,
    parameter logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_m0_data,
    input  logic [31:0] i_m0_address,
    input  logic [2:0]  i_m0_bhw,
    input  logic        i_m0_write_notread,
    input  logic        i_m0_DV,
    input  logic [31:0] i_m1_data,
    input  logic [31:0] i_m1_address,
    input  logic [2:0]  i_m1_bhw,
    input  logic        i_m1_write_notread,
    input  logic        i_m1_DV,
    output logic [31:0] o_m0_data,
    output logic        o_m0_DV,
    output logic [31:0] o_m1_data,
    output logic        o_m1_DV,
    output logic [31:0] o_bus_data,
    output logic [31:0] o_bus_address,
    output logic [2:0]  o_bhw,
    output logic        o_write_notread,
    output logic        o_bus_DV,
    input  logic [31:0] i_bus_data,
    input  logic        i_bus_DV,
    output logic [1:0]  o_overrun,
    output logic        o_timeout
);

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] address;
        logic [2:0]  bhw;
        logic        write_notread;
    } req_t;

    typedef enum logic {ST_IDLE, ST_WAIT} state_t;

    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

    state_t      state;
    logic        owner;
    logic        last_grant;
    logic [31:0] count;

    req_t        in_req [2];
    logic [1:0]  in_dv;
    req_t        slot [2];
    logic [1:0]  slot_valid;
    logic [1:0]  req;
    logic [1:0]  gnt;
    req_t        issue;
    logic        timed_out;
    logic        resp_fire;
    logic [31:0] resp_data;

    assign in_req[0] = {i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread};
    assign in_req[1] = {i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread};
    assign in_dv     = {i_m1_DV, i_m0_DV};

    always_comb begin
        req = slot_valid | in_dv;
        gnt = '0;
        if (state == ST_IDLE) begin
            if (req == 2'b11) gnt = last_grant ? 2'b01 : 2'b10;
            else              gnt = req;
        end
        // A pending slot always takes precedence over a same-cycle pulse (bypass only when empty)
        if (gnt[1]) issue = slot_valid[1] ? slot[1] : in_req[1];
        else        issue = slot_valid[0] ? slot[0] : in_req[0];

        timed_out = (state == ST_WAIT) && !i_bus_DV && (TIMEOUT != 0) && (count == TIMEOUT_LAST);
        resp_fire = (state == ST_WAIT) && (i_bus_DV || timed_out);
        resp_data = i_bus_DV ? i_bus_data : TIMEOUT_DATA;
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state           <= ST_IDLE;
            owner           <= 1'b0;
            last_grant      <= 1'b1;
            count           <= '0;
            slot_valid      <= '0;
            slot[0]         <= '0;
            slot[1]         <= '0;
            o_m0_data       <= '0;
            o_m0_DV         <= 1'b0;
            o_m1_data       <= '0;
            o_m1_DV         <= 1'b0;
            o_bus_data      <= '0;
            o_bus_address   <= '0;
            o_bhw           <= '0;
            o_write_notread <= 1'b0;
            o_bus_DV        <= 1'b0;
            o_overrun       <= '0;
            o_timeout       <= 1'b0;
        end else begin
            o_bus_DV <= 1'b0;
            o_m0_DV  <= 1'b0;
            o_m1_DV  <= 1'b0;

            for (int unsigned i = 0; i < 2; i++) begin
                if (gnt[i]) begin
                    // Slot drains on grant; a pulse arriving at the same edge refills it
                    if (slot_valid[i]) begin
                        slot[i]       <= in_req[i];
                        slot_valid[i] <= in_dv[i];
                    end
                end else if (in_dv[i]) begin
                    if (!slot_valid[i]) begin
                        slot[i]       <= in_req[i];
                        slot_valid[i] <= 1'b1;
                    end else begin
                        o_overrun[i] <= 1'b1;
                    end
                end
            end

            case (state)
                ST_IDLE: begin
                    if (|gnt) begin
                        owner      <= gnt[1];
                        last_grant <= gnt[1];
                        {o_bus_data, o_bus_address, o_bhw, o_write_notread} <= issue;
                        o_bus_DV   <= 1'b1;
                        count      <= '0;
                        state      <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    count <= count + 32'd1;
                    if (resp_fire) begin
                        if (owner) begin
                            o_m1_data <= resp_data;
                            o_m1_DV   <= 1'b1;
                        end else begin
                            o_m0_data <= resp_data;
                            o_m0_DV   <= 1'b1;
                        end
                        if (timed_out) o_timeout <= 1'b1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: table-driven single transactions plus scripted
// multi-cycle sequences, with scoreboard queues for bus issues and responses.
module tb_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [31:0] i_m0_data, i_m0_address, i_m1_data, i_m1_address;
    logic [2:0]  i_m0_bhw, i_m1_bhw;
    logic        i_m0_write_notread, i_m1_write_notread, i_m0_DV, i_m1_DV;
    logic [31:0] o_m0_data, o_m1_data, o_bus_data, o_bus_address;
    logic        o_m0_DV, o_m1_DV, o_write_notread, o_bus_DV, o_timeout;
    logic [2:0]  o_bhw;
    logic [31:0] i_bus_data;
    logic        i_bus_DV;
    logic [1:0]  o_overrun;

    int checks = 0;
    int failures = 0;

    bus_arbiter #(.TIMEOUT(8), .TIMEOUT_DATA(32'hDEADBEEF)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_m0_data(i_m0_data), .i_m0_address(i_m0_address), .i_m0_bhw(i_m0_bhw),
        .i_m0_write_notread(i_m0_write_notread), .i_m0_DV(i_m0_DV),
        .i_m1_data(i_m1_data), .i_m1_address(i_m1_address), .i_m1_bhw(i_m1_bhw),
        .i_m1_write_notread(i_m1_write_notread), .i_m1_DV(i_m1_DV),
        .o_m0_data(o_m0_data), .o_m0_DV(o_m0_DV), .o_m1_data(o_m1_data), .o_m1_DV(o_m1_DV),
        .o_bus_data(o_bus_data), .o_bus_address(o_bus_address), .o_bhw(o_bhw),
        .o_write_notread(o_write_notread), .o_bus_DV(o_bus_DV),
        .i_bus_data(i_bus_data), .i_bus_DV(i_bus_DV),
        .o_overrun(o_overrun), .o_timeout(o_timeout)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  bhw;
        logic        wnr;
    } bus_exp_t;

    typedef struct {
        int          m;
        logic [31:0] data;
    } resp_exp_t;

    typedef struct {
        int          m;
        logic        wnr;
        logic [31:0] address;
        logic [31:0] data;
        logic [2:0]  bhw;
        int          delay;
        logic [31:0] rdata;
    } vec_t;

    bus_exp_t  exp_bus[$];
    resp_exp_t exp_resp[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    // Scoreboard: every bus issue and master response must match the head of its queue
    always @(negedge i_clk) begin
        if (o_bus_DV === 1'b1) begin
            if (exp_bus.size() == 0) begin
                chk("bus_unexpected", {32'd0, o_bus_address}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                bus_exp_t e;
                e = exp_bus.pop_front();
                chk("bus_addr", {32'd0, o_bus_address}, {32'd0, e.address});
                chk("bus_fields", {28'd0, o_bus_data, o_bhw, o_write_notread},
                    {28'd0, e.data, e.bhw, e.wnr});
            end
        end
        if (o_m0_DV === 1'b1 || o_m1_DV === 1'b1) begin
            if (exp_resp.size() == 0) begin
                chk("resp_unexpected", {62'd0, o_m1_DV, o_m0_DV}, 64'd0);
            end else begin
                resp_exp_t r;
                r = exp_resp.pop_front();
                chk("resp_route", {62'd0, o_m1_DV, o_m0_DV}, (r.m == 1) ? 64'd2 : 64'd1);
                chk("resp_data", {32'd0, (r.m == 1) ? o_m1_data : o_m0_data}, {32'd0, r.data});
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic set_req(input int m, input logic wnr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [2:0] bhw);
        if (m == 0) begin
            i_m0_write_notread = wnr; i_m0_address = addr; i_m0_data = data; i_m0_bhw = bhw; i_m0_DV = 1'b1;
        end else begin
            i_m1_write_notread = wnr; i_m1_address = addr; i_m1_data = data; i_m1_bhw = bhw; i_m1_DV = 1'b1;
        end
    endtask

    task automatic pulse_req(input int m, input logic wnr, input logic [31:0] addr,
                             input logic [31:0] data, input logic [2:0] bhw);
        set_req(m, wnr, addr, data, bhw);
        tick();
        i_m0_DV = 1'b0;
        i_m1_DV = 1'b0;
    endtask

    task automatic push_bus(input logic [31:0] addr, input logic [31:0] data,
                            input logic [2:0] bhw, input logic wnr);
        bus_exp_t e;
        e.address = addr; e.data = data; e.bhw = bhw; e.wnr = wnr;
        exp_bus.push_back(e);
    endtask

    task automatic push_resp(input int m, input logic [31:0] data);
        resp_exp_t r;
        r.m = m; r.data = data;
        exp_resp.push_back(r);
    endtask

    task automatic mem_resp(input logic [31:0] data);
        i_bus_data = data;
        i_bus_DV   = 1'b1;
        tick();
        i_bus_DV   = 1'b0;
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
    endtask

    function automatic logic any_output();
        return |{o_m0_data, o_m1_data, o_m0_DV, o_m1_DV, o_bus_data, o_bus_address,
                 o_bhw, o_write_notread, o_bus_DV, o_overrun, o_timeout};
    endfunction

    vec_t vecs[4];

    initial begin
        int cnt;

        vecs[0] = '{m: 0, wnr: 1'b0, address: 32'h100, data: 32'h0,        bhw: 3'd2, delay: 3, rdata: 32'h12345678};
        vecs[1] = '{m: 1, wnr: 1'b1, address: 32'h104, data: 32'h55,       bhw: 3'd0, delay: 0, rdata: 32'h00000000};
        vecs[2] = '{m: 0, wnr: 1'b1, address: 32'h108, data: 32'hA5A5A5A5, bhw: 3'd1, delay: 5, rdata: 32'hCAFEF00D};
        vecs[3] = '{m: 1, wnr: 1'b0, address: 32'h10C, data: 32'h0,        bhw: 3'd4, delay: 7, rdata: 32'h0BADF00D};

        i_rst_n = 1'b0;
        {i_m0_data, i_m0_address, i_m0_bhw, i_m0_write_notread, i_m0_DV} = '0;
        {i_m1_data, i_m1_address, i_m1_bhw, i_m1_write_notread, i_m1_DV} = '0;
        i_bus_data = '0;
        i_bus_DV   = 1'b0;
        tick();
        tick();
        chk("reset_outputs", {63'd0, any_output()}, 64'd0);
        i_rst_n = 1'b1;
        tick();

        // Single transactions; delay 7 puts i_bus_DV on the timeout edge, where it must win
        for (int i = 0; i < 4; i++) begin
            push_bus(vecs[i].address, vecs[i].data, vecs[i].bhw, vecs[i].wnr);
            pulse_req(vecs[i].m, vecs[i].wnr, vecs[i].address, vecs[i].data, vecs[i].bhw);
            chk("issue_latency", {63'd0, o_bus_DV}, 64'd1);
            repeat (vecs[i].delay) tick();
            push_resp(vecs[i].m, vecs[i].rdata);
            mem_resp(vecs[i].rdata);
            chk("resp_pulse", {62'd0, o_m1_DV, o_m0_DV}, (vecs[i].m == 1) ? 64'd2 : 64'd1);
            tick();
        end
        chk("no_timeout_yet", {63'd0, o_timeout}, 64'd0);

        // Bus response while idle is ignored
        mem_resp(32'h77777777);
        chk("idle_bus_dv", {62'd0, o_m1_DV, o_m0_DV}, 64'd0);
        tick();

        // Simultaneous requests right after reset: m0 first, m1 one cycle after m0 response
        do_reset();
        push_bus(32'h200, 32'hAA, 3'd2, 1'b1);
        push_bus(32'h300, 32'h0, 3'd2, 1'b0);
        set_req(0, 1'b1, 32'h200, 32'hAA, 3'd2);
        set_req(1, 1'b0, 32'h300, 32'h0, 3'd2);
        tick();
        i_m0_DV = 1'b0;
        i_m1_DV = 1'b0;
        chk("simul_first_addr", {32'd0, o_bus_address}, 64'h200);
        tick();
        push_resp(0, 32'h11);
        mem_resp(32'h11);
        chk("simul_gap", {63'd0, o_bus_DV}, 64'd0);
        tick();
        chk("simul_second_issue", {31'd0, o_bus_DV, o_bus_address}, {31'd0, 1'b1, 32'h300});
        push_resp(1, 32'h22);
        mem_resp(32'h22);
        tick();

        // Fairness: each owner re-requests immediately after its response
        do_reset();
        push_bus(32'h500, 32'h0, 3'd2, 1'b0);
        push_bus(32'h600, 32'h0, 3'd2, 1'b0);
        set_req(0, 1'b0, 32'h500, 32'h0, 3'd2);
        set_req(1, 1'b0, 32'h600, 32'h0, 3'd2);
        tick();
        i_m0_DV = 1'b0;
        i_m1_DV = 1'b0;
        for (int t = 0; t < 6; t++) begin
            int m, k;
            m = t % 2;
            k = t / 2;
            chk("fair_issue", {63'd0, o_bus_DV}, 64'd1);
            tick();
            push_resp(m, 32'h1000 + 32'(t));
            mem_resp(32'h1000 + 32'(t));
            if (k < 2) begin
                push_bus(((m == 0) ? 32'h500 : 32'h600) + 32'(4 * (k + 1)), 32'h0, 3'd2, 1'b0);
                pulse_req(m, 1'b0, ((m == 0) ? 32'h500 : 32'h600) + 32'(4 * (k + 1)), 32'h0, 3'd2);
            end else begin
                tick();
            end
        end
        chk("fair_no_overrun", {62'd0, o_overrun}, 64'd0);

        // Overrun: second m1 pulse while m1 is already pending is dropped
        push_bus(32'h700, 32'h0, 3'd2, 1'b0);
        pulse_req(0, 1'b0, 32'h700, 32'h0, 3'd2);
        push_bus(32'h800, 32'h0, 3'd2, 1'b0);
        pulse_req(1, 1'b0, 32'h800, 32'h0, 3'd2);
        pulse_req(1, 1'b0, 32'h400, 32'h0, 3'd2);
        chk("overrun_flag", {62'd0, o_overrun}, 64'd2);
        push_resp(0, 32'h33);
        mem_resp(32'h33);
        tick();
        chk("overrun_issue", {32'd0, o_bus_address}, 64'h800);
        push_resp(1, 32'h44);
        mem_resp(32'h44);
        tick();

        // Timeout: memory never answers an m1 read
        push_bus(32'hA00, 32'h0, 3'd2, 1'b0);
        pulse_req(1, 1'b0, 32'hA00, 32'h0, 3'd2);
        push_resp(1, 32'hDEADBEEF);
        cnt = 0;
        while (o_m1_DV !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
        end
        chk("timeout_latency", 64'(cnt), 64'd8);
        chk("timeout_flag", {63'd0, o_timeout}, 64'd1);
        tick();
        push_bus(32'hB00, 32'h0, 3'd2, 1'b0);
        pulse_req(0, 1'b0, 32'hB00, 32'h0, 3'd2);
        tick();
        push_resp(0, 32'h55);
        mem_resp(32'h55);
        chk("after_timeout_resp", {63'd0, o_m0_DV}, 64'd1);
        tick();

        // Reset mid-WAIT abandons the transaction
        push_bus(32'hC00, 32'h0, 3'd2, 1'b0);
        pulse_req(0, 1'b0, 32'hC00, 32'h0, 3'd2);
        tick();
        do_reset();
        mem_resp(32'h99);
        chk("rst_wait_no_resp", {62'd0, o_m1_DV, o_m0_DV}, 64'd0);
        tick();
        chk("rst_wait_outputs", {63'd0, any_output()}, 64'd0);

        tick();
        chk("bus_queue_empty", 64'(exp_bus.size()), 64'd0);
        chk("resp_queue_empty", 64'(exp_resp.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
